// File: rtl/sram_port0_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sram_port0_arbiter: round-robin arbiter with bounded burst lock that shares |
// | the single RW port of a 32x256 SRAM macro between requesters A and B. Rev 1.0|
// +-----------------------------------------------------------------------------+
module sram_port0_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [NUM_WMASKS-1:0] a_wmask,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   input  logic                  a_lock,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [NUM_WMASKS-1:0] b_wmask,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   input  logic                  b_lock,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int            CW    = $clog2(MAX_BURST) + 1;
   localparam logic [CW-1:0] C_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

   port_t         last_gnt_q, last_gnt_d;
   logic          lock_valid_q, lock_valid_d;
   port_t         lock_owner_q, lock_owner_d;
   logic [CW-1:0] lock_cnt_q, lock_cnt_d;
   logic          rsp_pending_q, rsp_pending_d;
   port_t         rsp_port_q, rsp_port_d;

   logic          w_sel_a, w_sel_b, w_granted, w_active;
   port_t         w_gport;
   logic          w_gwe, w_glock, w_other_req, w_owner_req;
   logic [CW-1:0] w_cnt_inc;

   always_comb begin
      w_sel_a     = 1'b0;
      w_sel_b     = 1'b0;
      w_owner_req = (lock_owner_q == PORT_A) ? a_req : b_req;
      if (lock_valid_q && w_owner_req) begin
         w_sel_a = (lock_owner_q == PORT_A);
         w_sel_b = (lock_owner_q == PORT_B);
      end else if (a_req && !b_req) begin
         w_sel_a = 1'b1;
      end else if (b_req && !a_req) begin
         w_sel_b = 1'b1;
      end else if (a_req && b_req) begin
         w_sel_a = (last_gnt_q == PORT_B);
         w_sel_b = (last_gnt_q == PORT_A);
      end
   end

   assign w_granted   = w_sel_a | w_sel_b;
   assign w_gport     = w_sel_b ? PORT_B : PORT_A;
   assign w_gwe       = w_sel_b ? b_we   : a_we;
   assign w_glock     = w_sel_b ? b_lock : a_lock;
   assign w_other_req = w_sel_b ? a_req  : b_req;

   always_comb begin
      last_gnt_d    = w_granted ? w_gport : last_gnt_q;
      rsp_pending_d = w_granted && !w_gwe;
      rsp_port_d    = w_gport;
      lock_valid_d  = lock_valid_q;
      lock_owner_d  = lock_owner_q;
      lock_cnt_d    = lock_cnt_q;
      w_cnt_inc     = C_ONE;
      // An owner that stops requesting gives up the lock before the grant is judged
      if (lock_valid_q && !w_owner_req) begin
         lock_valid_d = 1'b0;
         lock_cnt_d   = '0;
      end
      if (w_granted) begin
         if (w_glock) begin
            if (lock_valid_d && lock_owner_d == w_gport) begin
               w_cnt_inc = (lock_cnt_q >= C_MAX) ? C_MAX : lock_cnt_q + C_ONE;
            end
            if (w_other_req && w_cnt_inc >= C_MAX) begin
               lock_valid_d = 1'b0;
               lock_cnt_d   = '0;
            end else begin
               lock_valid_d = 1'b1;
               lock_owner_d = w_gport;
               lock_cnt_d   = w_cnt_inc;
            end
         end else begin
            lock_valid_d = 1'b0;
            lock_cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q    <= PORT_B;
         lock_valid_q  <= 1'b0;
         lock_owner_q  <= PORT_A;
         lock_cnt_q    <= '0;
         rsp_pending_q <= 1'b0;
         rsp_port_q    <= PORT_A;
      end else begin
         last_gnt_q    <= last_gnt_d;
         lock_valid_q  <= lock_valid_d;
         lock_owner_q  <= lock_owner_d;
         lock_cnt_q    <= lock_cnt_d;
         rsp_pending_q <= rsp_pending_d;
         rsp_port_q    <= rsp_port_d;
      end
   end

   // Outputs are forced idle while reset is asserted, including in-flight responses
   assign w_active    = !reset && w_granted;
   assign a_gnt       = !reset && w_sel_a;
   assign b_gnt       = !reset && w_sel_b;
   assign sram_csb0   = !w_active;
   assign sram_web0   = w_active ? !w_gwe : 1'b1;
   assign sram_wmask0 = (w_active && w_gwe) ? (w_sel_b ? b_wmask : a_wmask) : '0;
   assign sram_addr0  = w_active ? (w_sel_b ? b_addr : a_addr) : '0;
   assign sram_din0   = w_active ? (w_sel_b ? b_wdata : a_wdata) : '0;

   assign a_rvalid = !reset && rsp_pending_q && (rsp_port_q == PORT_A);
   assign b_rvalid = !reset && rsp_pending_q && (rsp_port_q == PORT_B);
   assign a_rdata  = a_rvalid ? sram_dout0 : '0;
   assign b_rdata  = b_rvalid ? sram_dout0 : '0;

endmodule
`default_nettype wire

// File: tb/tb_sram_port0_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sram_port0_arbiter: directed bench with a behavioural SRAM macro model.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_sram_port0_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
   logic [3:0]  a_wmask, b_wmask;
   logic [7:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [31:0] a_rdata, b_rdata;
   logic        sram_csb0, sram_web0;
   logic [3:0]  sram_wmask0;
   logic [7:0]  sram_addr0;
   logic [31:0] sram_din0, sram_dout0;

   int vectors    = 0;
   int miscompares = 0;

   logic        pend;
   logic        pport;
   logic [31:0] pdata;

   always #5 clk = ~clk;

   sram_port0_arbiter dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_lock(a_lock), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
      .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
      .b_rdata(b_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
   );

   // Macro model: capture on posedge, perform the access at the following negedge
   logic [31:0] mem [256];
   logic        cap_v, cap_we;
   logic [7:0]  cap_addr;
   logic [31:0] cap_din;
   logic [3:0]  cap_mask;

   always @(posedge clk) begin
      cap_v    <= !sram_csb0;
      cap_we   <= !sram_web0;
      cap_addr <= sram_addr0;
      cap_din  <= sram_din0;
      cap_mask <= sram_wmask0;
   end

   always @(negedge clk) begin
      if (cap_v) begin
         if (cap_we) begin
            for (int i = 0; i < 4; i++)
               if (cap_mask[i]) mem[cap_addr][i*8 +: 8] <= cap_din[i*8 +: 8];
         end else begin
            sram_dout0 <= mem[cap_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks grants and the response owed from the previous cycle, then records this cycle's read
   task automatic cyc(input string tag, input logic ea, input logic eb,
                      input logic rd, input logic [31:0] d);
      @(negedge clk);
      #2;
      chk({tag, ".a_gnt"}, {31'b0, a_gnt}, {31'b0, ea});
      chk({tag, ".b_gnt"}, {31'b0, b_gnt}, {31'b0, eb});
      chk({tag, ".a_rvalid"}, {31'b0, a_rvalid}, {31'b0, pend && !pport});
      chk({tag, ".b_rvalid"}, {31'b0, b_rvalid}, {31'b0, pend && pport});
      if (pend) chk({tag, ".rdata"}, pport ? b_rdata : a_rdata, pdata);
      pend  = (ea | eb) && rd;
      pport = eb;
      pdata = d;
   endtask

   initial begin
      pend = 1'b0; pport = 1'b0; pdata = '0;
      reset = 1'b1;
      a_req = 1'b1; a_we = 1'b1; a_wmask = 4'hF; a_addr = 8'h10; a_wdata = 32'hDEADBEEF; a_lock = 1'b0;
      b_req = 1'b1; b_we = 1'b1; b_wmask = 4'hF; b_addr = 8'h02; b_wdata = 32'hB0B0B0B2; b_lock = 1'b0;
      cyc("rst", 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst.csb0", {31'b0, sram_csb0}, 32'h1);
      chk("rst.web0", {31'b0, sram_web0}, 32'h1);
      chk("rst.wmask0", {28'b0, sram_wmask0}, 32'h0);
      chk("rst.addr0", {24'b0, sram_addr0}, 32'h0);
      chk("rst.din0", sram_din0, 32'h0);

      tick(); reset = 1'b0;
      cyc("c1", 1'b1, 1'b0, 1'b0, 32'h0);
      chk("c1.csb0", {31'b0, sram_csb0}, 32'h0);
      chk("c1.web0", {31'b0, sram_web0}, 32'h0);
      chk("c1.addr0", {24'b0, sram_addr0}, 32'h10);
      chk("c1.din0", sram_din0, 32'hDEADBEEF);
      chk("c1.wmask0", {28'b0, sram_wmask0}, 32'hF);

      tick(); a_req = 1'b0;
      cyc("c2", 1'b0, 1'b1, 1'b0, 32'h0);
      chk("c2.addr0", {24'b0, sram_addr0}, 32'h02);

      tick(); b_req = 1'b0; a_req = 1'b1; a_we = 1'b0;
      cyc("c3", 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
      chk("c3.rd_wmask0", {28'b0, sram_wmask0}, 32'h0);
      chk("c3.rd_web0", {31'b0, sram_web0}, 32'h1);

      tick(); a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h20; b_wdata = 32'h11223344; b_wmask = 4'hF;
      cyc("c4", 1'b0, 1'b1, 1'b0, 32'h0);

      tick(); b_wdata = 32'hAAAAAAAA; b_wmask = 4'b0010;
      cyc("c5", 1'b0, 1'b1, 1'b0, 32'h0);
      chk("c5.wmask0", {28'b0, sram_wmask0}, 32'h2);

      tick(); b_we = 1'b0;
      cyc("c6", 1'b0, 1'b1, 1'b1, 32'h1122AA44);

      tick(); b_req = 1'b0;
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h01; a_wdata = 32'hA1A1A1A1; a_wmask = 4'hF;
      cyc("c7", 1'b1, 1'b0, 1'b0, 32'h0);

      tick(); a_we = 1'b0; b_req = 1'b1; b_addr = 8'h02;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         cyc("rr", (k % 2) == 1, (k % 2) == 0, 1'b1, ((k % 2) == 1) ? 32'hA1A1A1A1 : 32'hB0B0B0B2);
      end

      tick(); a_lock = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         cyc("lock", k != 4, k == 4, 1'b1, (k != 4) ? 32'hA1A1A1A1 : 32'hB0B0B0B2);
      end

      tick(); b_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         cyc("solo", 1'b1, 1'b0, 1'b1, 32'hA1A1A1A1);
      end

      tick(); b_req = 1'b1;
      cyc("sat_rel", 1'b1, 1'b0, 1'b1, 32'hA1A1A1A1);
      tick();
      cyc("sat_b", 1'b0, 1'b1, 1'b1, 32'hB0B0B0B2);

      tick(); a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0;
      cyc("idle", 1'b0, 1'b0, 1'b0, 32'h0);

      tick(); a_req = 1'b1;
      cyc("mr_rd", 1'b1, 1'b0, 1'b1, 32'hA1A1A1A1);
      tick(); reset = 1'b1; a_req = 1'b0;
      pend = 1'b0;
      cyc("mr_rst", 1'b0, 1'b0, 1'b0, 32'h0);
      tick(); reset = 1'b0; a_req = 1'b1; b_req = 1'b1;
      cyc("mr_post", 1'b1, 1'b0, 1'b1, 32'hA1A1A1A1);
      tick(); a_req = 1'b0; b_req = 1'b0;
      cyc("mr_rsp", 1'b0, 1'b0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
